// File: rtl/toast_core.sv
// rtl/toast_core.sv - multi-cycle RV32I core sharing one synchronous-read memory port
// toast_fetch : holds the latched instruction word IF_Instruction
//   clk_i, rst_ni    clock, async active-low reset
//   load_i           capture rd_data_i (asserted in DECODE)
//   rd_data_i        memory read data
//   instr_o          latched instruction
// toast_core  : FSM FETCH/DECODE/EXEC/MEM/WB/STORE/HALT, 3 cycles ALU/SW, 5 cycles loads/SB/SH
//   Clk, Reset_n     clock, async active-low reset
//   mem_rd_data      read data for the address presented in the previous cycle
//   mem_addr         byte address (memory decodes [31:2])
//   mem_wr_data      full-word write data
//   mem_wr_en        word write strobe
//   mem_rst          clears the memory read-data register
// Optional: define TOAST_HALT_ON_UNIMP_EN to halt on 32'hC0001073 in EXEC.

module toast_fetch (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] instr_o
);
  logic [31:0] IF_Instruction;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) IF_Instruction <= 32'h0;
    else if (load_i) IF_Instruction <= rd_data_i;
  end

  assign instr_o = IF_Instruction;
endmodule

module toast_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic        mem_rst
);
`ifdef TOAST_HALT_ON_UNIMP_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_STORE, S_HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, mem_addr_q, mem_wr_data_q, rs1_q, rs2_q, imm_q, ld_word_q;
  logic        mem_wr_en_q, rst_hold_q;
  logic [31:0] regs_q [32];
  logic [31:0] instr;

  toast_fetch IF_inst (
    .clk_i     (Clk),
    .rst_ni    (Reset_n),
    .load_i    (state_q == S_DECODE),
    .rd_data_i (mem_rd_data),
    .instr_o   (instr)
  );

  // Decode works directly on the word arriving from memory so that operands,
  // immediate and the load/store address are all registered on entry to EXEC.
  logic [31:0] dw, dec_imm_d, dec_rs1_d, dec_rs2_d;
  assign dw        = mem_rd_data;
  assign dec_rs1_d = regs_q[dw[19:15]];
  assign dec_rs2_d = regs_q[dw[24:20]];

  always_comb begin
    dec_imm_d = {{21{dw[31]}}, dw[30:20]};
    case (dw[6:0])
      OP_LUI, OP_AUIPC: dec_imm_d = {dw[31:12], 12'b0};
      OP_JAL:           dec_imm_d = {{12{dw[31]}}, dw[19:12], dw[20], dw[30:21], 1'b0};
      OP_BR:            dec_imm_d = {{20{dw[31]}}, dw[7], dw[30:25], dw[11:8], 1'b0};
      OP_ST:            dec_imm_d = {{21{dw[31]}}, dw[30:25], dw[11:7]};
      default:          dec_imm_d = {{21{dw[31]}}, dw[30:20]};
    endcase
  end

  logic [6:0] opc;
  logic [2:0] f3;
  logic [4:0] rd;
  logic       is_rmw, is_unimp;
  assign opc      = instr[6:0];
  assign f3       = instr[14:12];
  assign rd       = instr[11:7];
  assign is_rmw   = (opc == OP_ST) && (f3 == 3'b000 || f3 == 3'b001);
  assign is_unimp = (instr == 32'hC000_1073);

  logic [31:0] opb, alu_res, exec_res, next_pc;
  logic        exec_wr, take;

  always_comb begin
    opb = (opc == OP_ALU) ? rs2_q : imm_q;
    case (f3)
      // instr[30] only selects SUB for register-register ops; for ADDI it is an immediate bit
      3'b000:  alu_res = (opc == OP_ALU && instr[30]) ? rs1_q - opb : rs1_q + opb;
      3'b001:  alu_res = rs1_q << opb[4:0];
      3'b010:  alu_res = {31'b0, $signed(rs1_q) < $signed(opb)};
      3'b011:  alu_res = {31'b0, rs1_q < opb};
      3'b100:  alu_res = rs1_q ^ opb;
      3'b101:  alu_res = instr[30] ? $unsigned($signed(rs1_q) >>> opb[4:0]) : rs1_q >> opb[4:0];
      3'b110:  alu_res = rs1_q | opb;
      default: alu_res = rs1_q & opb;
    endcase
    case (f3)
      3'b000:  take = (rs1_q == rs2_q);
      3'b001:  take = (rs1_q != rs2_q);
      3'b100:  take = ($signed(rs1_q) < $signed(rs2_q));
      3'b101:  take = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110:  take = (rs1_q < rs2_q);
      3'b111:  take = (rs1_q >= rs2_q);
      default: take = 1'b0;
    endcase
    exec_res = alu_res;
    exec_wr  = 1'b0;
    next_pc  = pc_q + 32'd4;
    case (opc)
      OP_ALU, OP_ALUI: exec_wr = 1'b1;
      OP_LUI:   begin exec_res = imm_q;         exec_wr = 1'b1; end
      OP_AUIPC: begin exec_res = pc_q + imm_q;  exec_wr = 1'b1; end
      OP_JAL:   begin exec_res = pc_q + 32'd4;  exec_wr = 1'b1; next_pc = pc_q + imm_q; end
      OP_JALR:  begin exec_res = pc_q + 32'd4;  exec_wr = 1'b1; next_pc = (rs1_q + imm_q) & ~32'd1; end
      OP_BR:    if (take) next_pc = pc_q + imm_q;
      default:  ;
    endcase
  end

  // Load extraction from the captured word; the effective address is still held in mem_addr_q.
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_res, st_mask, st_data, st_merged;

  always_comb begin
    case (mem_addr_q[1:0])
      2'd0:    ld_b = ld_word_q[7:0];
      2'd1:    ld_b = ld_word_q[15:8];
      2'd2:    ld_b = ld_word_q[23:16];
      default: ld_b = ld_word_q[31:24];
    endcase
    ld_h = mem_addr_q[1] ? ld_word_q[31:16] : ld_word_q[15:0];
    case (f3)
      3'b000:  ld_res = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_res = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_res = {24'b0, ld_b};
      3'b101:  ld_res = {16'b0, ld_h};
      default: ld_res = ld_word_q;
    endcase
    st_mask   = (f3 == 3'b000) ? (32'h0000_00FF << {mem_addr_q[1:0], 3'b000})
                               : (32'h0000_FFFF << {mem_addr_q[1], 4'b0000});
    st_data   = (f3 == 3'b000) ? {4{rs2_q[7:0]}} : {2{rs2_q[15:0]}};
    st_merged = (mem_rd_data & ~st_mask) | (st_data & st_mask);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_wr_data_q <= 32'h0;
      mem_wr_en_q   <= 1'b0;
      rst_hold_q    <= 1'b1;
      rs1_q         <= 32'h0;
      rs2_q         <= 32'h0;
      imm_q         <= 32'h0;
      ld_word_q     <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      rst_hold_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      case (state_q)
        // The memory output is held clear during the first cycle after reset, so fetch waits it out.
        S_FETCH: if (!rst_hold_q) state_q <= S_DECODE;
        S_DECODE: begin
          rs1_q   <= dec_rs1_d;
          rs2_q   <= dec_rs2_d;
          imm_q   <= dec_imm_d;
          state_q <= S_EXEC;
          if (dw[6:0] == OP_LD || dw[6:0] == OP_ST) mem_addr_q <= dec_rs1_d + dec_imm_d;
          if (dw[6:0] == OP_ST && dw[14:12] == 3'b010) begin
            mem_wr_en_q   <= 1'b1;
            mem_wr_data_q <= dec_rs2_d;
          end
        end
        S_EXEC: begin
          if (HaltEn && is_unimp) begin
            state_q <= S_HALT;
          end else if (opc == OP_LD || is_rmw) begin
            state_q <= S_MEM;
          end else begin
            if (exec_wr && rd != 5'd0) regs_q[rd] <= exec_res;
            pc_q       <= next_pc;
            mem_addr_q <= next_pc;
            state_q    <= S_FETCH;
          end
        end
        S_MEM: begin
          ld_word_q <= mem_rd_data;
          if (is_rmw) begin
            mem_wr_data_q <= st_merged;
            mem_wr_en_q   <= 1'b1;
            state_q       <= S_STORE;
          end else begin
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs_q[rd] <= ld_res;
          pc_q       <= pc_q + 32'd4;
          mem_addr_q <= pc_q + 32'd4;
          state_q    <= S_FETCH;
        end
        S_STORE: begin
          pc_q       <= pc_q + 32'd4;
          mem_addr_q <= pc_q + 32'd4;
          state_q    <= S_FETCH;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_rst     = rst_hold_q;
endmodule

// File: tb/tb_toast_core.sv
// tb/tb_toast_core.sv - directed self-checking bench for toast_core
module tb_toast_core;
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [31:0] mem_rd_data, mem_addr, mem_wr_data;
  logic        mem_wr_en, mem_rst;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [256];
  logic [31:0] rd_q;
  int          wr_cnt = 0;
  int          w0;
  logic [31:0] last_wa, last_wd;

  always #5 Clk = ~Clk;

  toast_core UUT (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .mem_rd_data (mem_rd_data),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rst     (mem_rst)
  );

  assign mem_rd_data = rd_q;

  always @(posedge Clk) begin
    if (mem_wr_en === 1'b1) begin
      mem[mem_addr[9:2]] <= mem_wr_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
      last_wd <= mem_wr_data;
    end
    rd_q <= (mem_rst !== 1'b0) ? 32'h0 : mem[mem_addr[9:2]];
  end

  function automatic logic [31:0] f_sw(input logic [4:0] rs2, input logic [11:0] off);
    return {off[11:5], rs2, 5'd0, 3'b010, off[4:0], 7'b0100011};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic begin_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  task automatic release_reset();
    repeat (10) @(negedge Clk);
    Reset_n = 1'b1;
    w0 = wr_cnt;
  endtask

  task automatic test_reset();
    begin_reset();
    mem[0] = 32'h0050_0093;
    repeat (10) @(negedge Clk);
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=%h", mem_addr, 32'h0); end
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", mem_wr_en); end
    total++; if (mem_wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", mem_wr_data); end
    total++; if (mem_rst !== 1'b1) begin bad++; $display("FAIL rst_mem_rst got=%b exp=1", mem_rst); end
    Reset_n = 1'b1;
    #1;
    total++; if (mem_rst !== 1'b1) begin bad++; $display("FAIL rst_mem_rst_release got=%b exp=1", mem_rst); end
    @(negedge Clk);
    total++; if (mem_rst !== 1'b0) begin bad++; $display("FAIL rst_mem_rst_drop got=%b exp=0", mem_rst); end
    step(2);
    total++; if (UUT.IF_inst.IF_Instruction !== 32'h0050_0093) begin bad++; $display("FAIL rst_first_fetch got=%h exp=%h", UUT.IF_inst.IF_Instruction, 32'h0050_0093); end
  endtask

  task automatic test_alu();
    begin_reset();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8133;
    release_reset();
    step(3);
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL alu_addr0 got=%h exp=%h", mem_addr, 32'h0); end
    step(1);
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL alu_addr4 got=%h exp=%h", mem_addr, 32'h4); end
    step(2);
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL alu_addr4_hold got=%h exp=%h", mem_addr, 32'h4); end
    step(1);
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL alu_addr8 got=%h exp=%h", mem_addr, 32'h8); end
  endtask

  task automatic test_word_store();
    begin_reset();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8133;
    mem[2] = f_sw(5'd2, 12'h008);
    release_reset();
    step(8);
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL sw_pre_en got=%b exp=0", mem_wr_en); end
    step(1);
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL sw_en got=%b exp=1", mem_wr_en); end
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL sw_addr got=%h exp=%h", mem_addr, 32'h8); end
    total++; if (mem_wr_data !== 32'h0000_000A) begin bad++; $display("FAIL sw_data got=%h exp=%h", mem_wr_data, 32'h0000_000A); end
    #2 Reset_n = 1'b0;
    #1;
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL sw_abort_en got=%b exp=0", mem_wr_en); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL sw_abort_addr got=%h exp=%h", mem_addr, 32'h0); end
    @(negedge Clk);
    total++; if (mem[2] !== f_sw(5'd2, 12'h008)) begin bad++; $display("FAIL sw_abort_mem got=%h exp=%h", mem[2], f_sw(5'd2, 12'h008)); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL sw_abort_cnt got=%0d exp=0", wr_cnt - w0); end
  endtask

  task automatic test_byte_store();
    begin_reset();
    mem[0] = 32'h0AB0_0193;
    mem[1] = 32'h0030_08A3;
    mem[4] = 32'h1122_3344;
    release_reset();
    step(6);
    total++; if (mem_wr_en !== 1'b0) begin bad++; $display("FAIL sb_exec_en got=%b exp=0", mem_wr_en); end
    step(2);
    total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL sb_store_en got=%b exp=1", mem_wr_en); end
    step(12);
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL sb_cnt got=%0d exp=1", wr_cnt - w0); end
    total++; if (last_wa !== 32'h11) begin bad++; $display("FAIL sb_addr got=%h exp=%h", last_wa, 32'h11); end
    total++; if (last_wd !== 32'h1122_AB44) begin bad++; $display("FAIL sb_data got=%h exp=%h", last_wd, 32'h1122_AB44); end
    total++; if (mem[4] !== 32'h1122_AB44) begin bad++; $display("FAIL sb_mem got=%h exp=%h", mem[4], 32'h1122_AB44); end
  endtask

  task automatic test_loads();
    begin_reset();
    mem[0]  = 32'h0200_0203;
    mem[1]  = 32'h0200_4283;
    mem[2]  = 32'h0200_1303;
    mem[3]  = 32'h0210_0383;
    mem[4]  = 32'h0220_2403;
    mem[5]  = 32'h02C0_006F;
    mem[8]  = 32'h0000_80FF;
    mem[16] = f_sw(5'd4, 12'h080);
    mem[17] = f_sw(5'd5, 12'h084);
    mem[18] = f_sw(5'd6, 12'h088);
    mem[19] = f_sw(5'd7, 12'h08C);
    mem[20] = f_sw(5'd8, 12'h090);
    release_reset();
    step(60);
    total++; if (mem[32] !== 32'hFFFF_FFFF) begin bad++; $display("FAIL ld_lb got=%h exp=%h", mem[32], 32'hFFFF_FFFF); end
    total++; if (mem[33] !== 32'h0000_00FF) begin bad++; $display("FAIL ld_lbu got=%h exp=%h", mem[33], 32'h0000_00FF); end
    total++; if (mem[34] !== 32'hFFFF_80FF) begin bad++; $display("FAIL ld_lh got=%h exp=%h", mem[34], 32'hFFFF_80FF); end
    total++; if (mem[35] !== 32'hFFFF_FF80) begin bad++; $display("FAIL ld_lb_off1 got=%h exp=%h", mem[35], 32'hFFFF_FF80); end
    total++; if (mem[36] !== 32'h0000_80FF) begin bad++; $display("FAIL ld_lw_misal got=%h exp=%h", mem[36], 32'h0000_80FF); end
  endtask

  task automatic test_alu_mix();
    begin_reset();
    mem[0] = 32'hFF00_0093;
    mem[1] = 32'h4020_D113;
    mem[2] = 32'h01C0_D193;
    mem[3] = 32'hFFF0_3213;
    mem[4] = 32'h0000_A2B3;
    mem[5] = 32'h4010_0333;
    mem[6] = 32'h1234_53B7;
    mem[7] = 32'h0000_1417;
    for (int r = 2; r <= 8; r++) mem[6 + r] = f_sw(5'(r), 12'(32'h80 + 4 * (r - 1)));
    release_reset();
    step(60);
    total++; if (mem[33] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL mix_srai got=%h exp=%h", mem[33], 32'hFFFF_FFFC); end
    total++; if (mem[34] !== 32'h0000_000F) begin bad++; $display("FAIL mix_srli got=%h exp=%h", mem[34], 32'h0000_000F); end
    total++; if (mem[35] !== 32'h0000_0001) begin bad++; $display("FAIL mix_sltiu got=%h exp=%h", mem[35], 32'h1); end
    total++; if (mem[36] !== 32'h0000_0001) begin bad++; $display("FAIL mix_slt got=%h exp=%h", mem[36], 32'h1); end
    total++; if (mem[37] !== 32'h0000_0010) begin bad++; $display("FAIL mix_sub got=%h exp=%h", mem[37], 32'h10); end
    total++; if (mem[38] !== 32'h1234_5000) begin bad++; $display("FAIL mix_lui got=%h exp=%h", mem[38], 32'h1234_5000); end
    total++; if (mem[39] !== 32'h0000_101C) begin bad++; $display("FAIL mix_auipc got=%h exp=%h", mem[39], 32'h101C); end
  endtask

  task automatic test_control();
    begin_reset();
    mem[0] = 32'h00C0_00EF;
    mem[3] = f_sw(5'd1, 12'h060);
    mem[4] = 32'h0014_8493;
    mem[5] = f_sw(5'd9, 12'h064);
    mem[6] = 32'hFE00_0CE3;
    release_reset();
    step(4);
    total++; if (mem_addr !== 32'hC) begin bad++; $display("FAIL jal_target got=%h exp=%h", mem_addr, 32'hC); end
    step(12);
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL beq_target got=%h exp=%h", mem_addr, 32'h10); end
    total++; if (mem[24] !== 32'h4) begin bad++; $display("FAIL jal_link got=%h exp=%h", mem[24], 32'h4); end
    total++; if (mem[25] !== 32'h1) begin bad++; $display("FAIL loop_iter1 got=%h exp=%h", mem[25], 32'h1); end
    step(9);
    total++; if (mem[25] !== 32'h2) begin bad++; $display("FAIL loop_iter2 got=%h exp=%h", mem[25], 32'h2); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL beq_target2 got=%h exp=%h", mem_addr, 32'h10); end
  endtask

  task automatic test_halt();
    begin_reset();
    mem[0] = 32'h0050_0093;
    mem[1] = 32'hC000_1073;
    mem[2] = f_sw(5'd1, 12'h060);
    release_reset();
    step(6);
    total++; if (UUT.IF_inst.IF_Instruction !== 32'hC000_1073) begin bad++; $display("FAIL unimp_latch got=%h exp=%h", UUT.IF_inst.IF_Instruction, 32'hC000_1073); end
    step(40);
`ifdef TOAST_HALT_ON_UNIMP_EN
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL halt_addr got=%h exp=%h", mem_addr, 32'h4); end
    total++; if (UUT.IF_inst.IF_Instruction !== 32'hC000_1073) begin bad++; $display("FAIL halt_instr got=%h exp=%h", UUT.IF_inst.IF_Instruction, 32'hC000_1073); end
    total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL halt_writes got=%0d exp=0", wr_cnt - w0); end
`else
    total++; if (mem[24] !== 32'h5) begin bad++; $display("FAIL unimp_nop got=%h exp=%h", mem[24], 32'h5); end
    total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL unimp_writes got=%0d exp=1", wr_cnt - w0); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_word_store();
    test_byte_store();
    test_loads();
    test_alu_mix();
    test_control();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/toast_core.md
Name: toast_core

Overview:
- toast_core is a compact multi-cycle RV32I integer core. It uses one shared, word-wide, synchronous-read memory port for both instruction fetch and data access.
- It is the top-level CPU block: a memory model/BRAM sits beside it, and the bench watches its fetch stage to detect end-of-test.
- It executes the base RV32I user ISA. FENCE, ECALL, EBREAK and CSR instructions execute as NOPs, except the halt encoding defined under Optional Feature.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  input  1  rising-edge system clock.
- Reset_n  input  1  reset; one clock domain, asynchronous assert, active-low.
- mem_rd_data  input  32  read data for the address presented in the previous cycle.
- mem_addr  output  32  byte address. Memory uses mem_addr[31:2] only.
- mem_wr_data  output  32  full-word write data.
- mem_wr_en  output  1  write strobe; memory writes the word at the rising edge while high.
- mem_rst  output  1  clears the memory's read-data output register.

Behaviour:
- Reset (Reset_n low, asynchronous) sets:
  - PC=RESET_PC, state=FETCH, all 32 registers=0.
  - mem_wr_en=0, mem_addr=RESET_PC, mem_wr_data=0.
  - mem_rst=1 while Reset_n is low and for the first cycle after release; 0 otherwise.
- Memory contract: address sampled at the rising edge; data valid on mem_rd_data during the next cycle. Byte order is little-endian.
- Fetch hierarchy: the fetch logic is instance IF_inst, and its latched instruction register is IF_Instruction. The verification bench probes UUT.IF_inst.IF_Instruction.
- States: FETCH, DECODE, EXEC, MEM, WB, STORE, HALT.
- FETCH: mem_addr=PC. Next state DECODE.
- DECODE: IF_Instruction<=mem_rd_data. Source registers rs1/rs2 are read; immediate is generated. Next state EXEC.
- EXEC for ALU / LUI / AUIPC / JAL / JALR / branch:
  - Computes the result, writes rd, updates PC, returns to FETCH. Total: 3 cycles per instruction.
  - Writes to x0 are discarded.
- EXEC for loads: mem_addr=rs1+imm, then MEM, then WB. WB extracts the byte/half, sign- or zero-extends it, writes rd, PC+=4. Total: 5 cycles.
  - LW ignores addr[1:0].
  - LH/LHU select the half by addr[1].
  - LB/LBU select the byte by addr[1:0].
- SW in EXEC: mem_addr=rs1+imm, mem_wr_data=rs2, mem_wr_en=1 for exactly that cycle. Total: 3 cycles.
- SB/SH (read-modify-write):
  - EXEC issues a read; MEM captures the word.
  - STORE writes the merged word with mem_wr_en=1 for one cycle.
  - Total: 5 cycles.
  - Only the addressed byte/half changes.
- Arithmetic and control-flow rules:
  - Arithmetic is 32-bit with wrap-around; no exceptions.
  - Shift amount is rs2[4:0] or shamt. SRA/SRAI sign-fill.
  - SLT/SLTI are signed. SLTU/SLTIU are unsigned; SLTIU still sign-extends its immediate.
  - Branch/JAL target = PC+imm. JALR target = (rs1+imm) with bit0 cleared. Link = PC+4; when rd==rs1, the link is written after the target is computed from the old rs1.
  - Misaligned targets are not trapped; PC[1:0] are ignored by memory.
- Unknown opcodes execute as NOPs (PC+=4).
- mem_wr_en is 0 in every state other than the SW EXEC cycle and the STORE cycle.
- Reset asserted mid-instruction aborts it immediately; any pending write is dropped.

Optional Feature:
- Macro TOAST_HALT_ON_UNIMP_EN.
- Defined: IF_Instruction==32'hC0001073 (unimp) in EXEC moves the core to HALT. HALT holds PC, mem_addr and IF_Instruction frozen, keeps mem_wr_en=0, and is left only by reset.
- Undefined: 32'hC0001073 executes as a NOP (PC+=4).

Test Plan:
- Reset: hold Reset_n=0 for 100 ns -> mem_addr=0, mem_wr_en=0, mem_rst=1. After release, mem_rst drops after one cycle and the first fetch reads address 0.
- ALU: ADDI x1,x0,5 (0x00500093) then ADD x2,x1,x1 (0x00108133) -> x2=10. mem_addr shows 0, 4, 8 at 3-cycle spacing.
- Word store: x2=10, then SW x2,8(x0) -> one cycle with mem_wr_en=1, mem_addr=8, mem_wr_data=0x0000000A.
- Byte store: mem[0x10]=0x11223344, x3=0xAB, SB x3,0x11(x0) -> single write of 0x1122AB44 to 0x10.
- Loads: mem[0x20]=0x000080FF -> LB (offset 0x20)=0xFFFFFFFF, LBU=0x000000FF, LH (offset 0x20)=0xFFFF80FF.
- Control/halt: BEQ x0,x0,-8 at 0x18 -> next fetch at 0x10. JAL x1,+12 at 0x0 -> x1=4, fetch at 0xC. With TOAST_HALT_ON_UNIMP_EN defined, 0xC0001073 -> IF_Instruction held at 0xC0001073 and no further fetches.
